// File: rtl/wb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_bram_arbiter
// Purpose  : Two-master Wishbone arbiter in front of a single-port BRAM.
//            M0 (instruction fetch) and M1 (data) share one slave port.
//            A master holds the slave from grant until it drops cyc;
//            contention is resolved round-robin. A stall watchdog returns
//            err to the owner and frees the slave if ack never arrives.
// Revision : 1.0 - initial release
// ============================================================================
module wb_bram_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // master 0 (instruction fetch)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1 (data)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // shared slave port
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  localparam logic [1:0]      ST_IDLE   = 2'd0;
  localparam logic [1:0]      ST_OWN0   = 2'd1;
  localparam logic [1:0]      ST_OWN1   = 2'd2;
  localparam logic [TO_W-1:0] C_TIMEOUT = TO_W'(TIMEOUT);
  localparam logic            C_WD_EN   = (TIMEOUT != 0);

  logic [1:0]      state_q, state_d;
  logic            last_q, last_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic w_own0;
  logic w_own1;
  logic w_err;
  logic w_rearb;
  logic w_req0;
  logic w_req1;

  assign w_own0 = (state_q == ST_OWN0);
  assign w_own1 = (state_q == ST_OWN1);

  // Read data is broadcast; only the ack tells a master the data is its own.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Slave port mux driven purely from the owner; IDLE parks everything at 0.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'h0;
    s_adr_o = 32'h0;
    s_dat_o = 32'h0;
    if (w_own0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i & m0_cyc_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (w_own1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i & m1_cyc_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  // Ack/err routing; err needs !s_ack_i so the two can never coincide.
  always_comb begin
    w_err    = C_WD_EN & s_stb_o & ~s_ack_i & (cnt_q == C_TIMEOUT);
    m0_ack_o = w_own0 & m0_cyc_i & m0_stb_i & s_ack_i;
    m1_ack_o = w_own1 & m1_cyc_i & m1_stb_i & s_ack_i;
    m0_err_o = w_own0 & w_err;
    m1_err_o = w_own1 & w_err;
  end

  // Decide when to re-arbitrate; an owner released by err is excluded.
  always_comb begin
    w_req0  = m0_cyc_i;
    w_req1  = m1_cyc_i;
    w_rearb = 1'b0;
    case (state_q)
      ST_OWN0: begin
        w_rearb = ~m0_cyc_i | w_err;
        if (w_err) w_req0 = 1'b0;
      end
      ST_OWN1: begin
        w_rearb = ~m1_cyc_i | w_err;
        if (w_err) w_req1 = 1'b0;
      end
      default: w_rearb = 1'b1;
    endcase
  end

  // Round-robin grant: on contention the master that did not own last wins.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (w_rearb) begin
      state_d = ST_IDLE;
      if (w_req0 && (!w_req1 || last_q)) begin
        state_d = ST_OWN0;
        last_d  = 1'b0;
      end else if (w_req1) begin
        state_d = ST_OWN1;
        last_d  = 1'b1;
      end
    end
  end

  // Watchdog counts stalled owner strobes, saturating at the limit.
  always_comb begin
    if ((state_d != state_q) || s_ack_i || !s_stb_o) begin
      cnt_d = '0;
    end else if (cnt_q != C_TIMEOUT) begin
      cnt_d = cnt_q + TO_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset wins even in the middle of a transfer.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_bram_arbiter
// Purpose  : Scoreboard bench for wb_bram_arbiter. Instance "a" uses a short
//            watchdog (TIMEOUT=4) with a combinational BRAM model; instance
//            "b" has the watchdog disabled and a slave that never acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_bram_arbiter;

  logic clk;
  logic rst_n;
  logic ack_en;

  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_dat;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_dat;

  logic [31:0] a_m0_dat, a_m1_dat;
  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
  logic        a_s_cyc, a_s_stb, a_s_we;
  logic [3:0]  a_s_sel;
  logic [31:0] a_s_adr, a_s_dato, a_s_dati;
  logic        a_s_ack;

  logic [31:0] b_m0_dat, b_m1_dat;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
  logic        b_s_cyc, b_s_stb, b_s_we;
  logic [3:0]  b_s_sel;
  logic [31:0] b_s_adr, b_s_dato, b_s_dati;
  logic        b_s_ack;

  // BRAM model: acks combinationally, read data is the inverted address
  assign a_s_ack  = a_s_cyc & a_s_stb & ack_en;
  assign a_s_dati = ~a_s_adr;
  assign b_s_ack  = 1'b0;
  assign b_s_dati = ~b_s_adr;

  wb_bram_arbiter #(.TIMEOUT(4), .TO_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(a_m0_dat),
    .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(a_m1_dat),
    .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_sel_o(a_s_sel),
    .s_adr_o(a_s_adr), .s_dat_o(a_s_dato), .s_dat_i(a_s_dati), .s_ack_i(a_s_ack)
  );

  wb_bram_arbiter #(.TIMEOUT(0), .TO_W(8)) dut_nt (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(b_m0_dat),
    .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(b_m1_dat),
    .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_sel_o(b_s_sel),
    .s_adr_o(b_s_adr), .s_dat_o(b_s_dato), .s_dat_i(b_s_dati), .s_ack_i(b_s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // event code bits: {m1_err, m0_err, m1_ack, m0_ack}
  localparam logic [3:0] EV_ACK0 = 4'b0001;
  localparam logic [3:0] EV_ACK1 = 4'b0010;
  localparam logic [3:0] EV_ERR0 = 4'b0100;

  typedef struct {
    logic [3:0]  ev;
    logic [31:0] dat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input logic [3:0] ev, input logic [31:0] dat);
    exp_t e;
    e.ev  = ev;
    e.dat = dat;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic c, input logic [31:0] adr);
    m0_cyc = c; m0_stb = c; m0_we = 1'b0; m0_sel = 4'hF;
    m0_adr = adr; m0_dat = adr ^ 32'hA5A5_0000;
  endtask

  task automatic drv1(input logic c, input logic [31:0] adr);
    m1_cyc = c; m1_stb = c; m1_we = 1'b1; m1_sel = 4'h3;
    m1_adr = adr; m1_dat = adr ^ 32'h0000_5A5A;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Monitor: every ack/err presented by instance "a" must match the queue head
  always @(negedge clk) begin
    logic [3:0]  ev;
    logic [31:0] d;
    exp_t        e;
    ev = {a_m1_err, a_m0_err, a_m1_ack, a_m0_ack};
    if (ev != 4'b0000) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got ev=%b dat0=%h dat1=%h want no event",
                 ev, a_m0_dat, a_m1_dat);
      end else begin
        e = sb_q.pop_front();
        d = ev[1] ? a_m1_dat : a_m0_dat;
        if (ev != e.ev || ((ev[0] | ev[1]) && d !== e.dat)) begin
          errors++;
          $display("FAIL sb_event got ev=%b dat=%h want ev=%b dat=%h",
                   ev, d, e.ev, e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n  = 1'b0;
    ack_en = 1'b1;
    drv0(1'b1, 32'h40);
    drv1(1'b0, 32'h0);

    // ---- reset state: a requesting master must not reach the slave
    step();
    step();
    @(negedge clk);
    chk("rst_s_cyc", a_s_cyc, 0);
    chk("rst_s_stb", a_s_stb, 0);
    chk("rst_s_adr", a_s_adr, 32'h0);
    chk("rst_acks",  {a_m0_ack, a_m1_ack, a_m0_err, a_m1_err}, 0);
    chk("rst_dat_bcast", a_m0_dat, 32'hFFFF_FFFF);
    step();
    rst_n = 1'b1;
    drv0(1'b0, 32'h0);

    // ---- 1: M0 read alone
    step();
    drv0(1'b1, 32'h100);
    @(negedge clk);
    chk("t1_idle_latency", a_s_cyc, 0);
    step();
    push(EV_ACK0, ~32'h100);
    @(negedge clk);
    chk("t1_s_adr", a_s_adr, 32'h100);
    chk("t1_s_cyc", a_s_cyc, 1);
    chk("t1_s_sel", a_s_sel, 4'hF);
    chk("t1_m1_ack", a_m1_ack, 0);
    step();
    drv0(1'b0, 32'h0);
    @(negedge clk);
    chk("t1_release_cyc", a_s_cyc, 0);

    // ---- 2: simultaneous request after reset, handover without gap
    do_reset();
    step();
    drv0(1'b1, 32'h200);
    drv1(1'b1, 32'h300);
    for (int i = 0; i < 3; i++) begin
      step();
      drv0(1'b1, 32'h200 + 32'(4 * i));
      push(EV_ACK0, ~(32'h200 + 32'(4 * i)));
      @(negedge clk);
      chk("t2_m0_adr", a_s_adr, 32'h200 + 32'(4 * i));
    end
    step();
    drv0(1'b0, 32'h0);
    @(negedge clk);
    chk("t2_drop_m1_ack", a_m1_ack, 0);
    step();
    push(EV_ACK1, ~32'h300);
    @(negedge clk);
    chk("t2_handover_adr", a_s_adr, 32'h300);
    chk("t2_handover_cyc", a_s_cyc, 1);
    chk("t2_m1_we", a_s_we, 1);
    step();
    drv1(1'b0, 32'h0);
    step();
    drv0(1'b1, 32'h400);
    drv1(1'b1, 32'h304);
    step();
    push(EV_ACK0, ~32'h400);
    @(negedge clk);
    chk("t2_rr_m0", a_s_adr, 32'h400);
    step();
    drv0(1'b0, 32'h0);
    drv1(1'b0, 32'h0);

    // ---- 3: contention with last=M0 goes to M1; M0 waits for cyc drop
    step();
    drv0(1'b1, 32'h500);
    drv1(1'b1, 32'h600);
    for (int i = 0; i < 10; i++) begin
      step();
      drv1(1'b1, 32'h600 + 32'(4 * i));
      push(EV_ACK1, ~(32'h600 + 32'(4 * i)));
      @(negedge clk);
      chk("t3_m1_adr", a_s_adr, 32'h600 + 32'(4 * i));
      chk("t3_m0_ack", a_m0_ack, 0);
    end
    step();
    drv1(1'b0, 32'h0);
    @(negedge clk);
    chk("t3_drop_cyc", a_s_cyc, 0);
    step();
    push(EV_ACK0, ~32'h500);
    @(negedge clk);
    chk("t3_m0_grant", a_s_adr, 32'h500);
    step();
    drv0(1'b0, 32'h0);

    // ---- 4: watchdog fires in the 5th stalled owned cycle, M1 takes over
    step();
    ack_en = 1'b0;
    drv0(1'b1, 32'h700);
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 3) drv1(1'b1, 32'h800);
      if (i == 5) push(EV_ERR0, 32'h0);
      @(negedge clk);
      chk("t4_m0_err", a_m0_err, (i == 5) ? 1 : 0);
    end
    step();
    ack_en = 1'b1;
    push(EV_ACK1, ~32'h800);
    @(negedge clk);
    chk("t4_after_err_adr", a_s_adr, 32'h800);
    chk("t4_err_one_cycle", a_m0_err, 0);
    step();
    drv1(1'b0, 32'h0);
    step();
    push(EV_ACK0, ~32'h700);
    @(negedge clk);
    chk("t4_regrant_m0", a_s_adr, 32'h700);
    step();
    drv0(1'b0, 32'h0);

    // ---- 5: reset in the middle of an M1 burst
    step();
    drv1(1'b1, 32'h900);
    for (int i = 0; i < 2; i++) begin
      step();
      drv1(1'b1, 32'h900 + 32'(4 * i));
      push(EV_ACK1, ~(32'h900 + 32'(4 * i)));
    end
    step();
    rst_n = 1'b0;
    drv1(1'b1, 32'h908);
    drv0(1'b1, 32'hA00);
    push(EV_ACK1, ~32'h908);
    step();
    @(negedge clk);
    chk("t5_rst_s_cyc", a_s_cyc, 0);
    chk("t5_rst_acks", {a_m0_ack, a_m1_ack, a_m0_err, a_m1_err}, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_release_idle", a_s_cyc, 0);
    step();
    push(EV_ACK0, ~32'hA00);
    @(negedge clk);
    chk("t5_m0_wins", a_s_adr, 32'hA00);
    step();
    drv0(1'b0, 32'h0);
    drv1(1'b0, 32'h0);

    // ---- 6: disabled watchdog never fires on a permanently stalled slave
    step();
    drv0(1'b1, 32'hB00);
    for (int i = 0; i < 1000; i++) begin
      step();
      push(EV_ACK0, ~32'hB00);
      @(negedge clk);
      chk("t6_nt_s_cyc", b_s_cyc, 1);
      chk("t6_nt_err", {b_m0_err, b_m1_err}, 0);
    end
    step();
    drv0(1'b0, 32'h0);
    step();
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
